// File: rtl/edge_event_serializer_if.sv
// Event output port of the edge event serializer.
// Carries one event index per valid/ready transfer.
interface edge_event_serializer_if #(
   parameter int IDXW = 5
);
   logic            out_valid;
   logic            out_ready;
   logic [IDXW-1:0] out_index;

   modport master (
      output out_valid,
      output out_index,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_index,
      output out_ready
   );
endinterface

// File: rtl/edge_event_serializer.sv
// Turns newly set bits of a sticky capture vector into a
// round-robin stream of event indices with a duplicate counter.
module edge_event_serializer #(
   parameter int WIDTH = 32,
   parameter int IDXW  = $clog2(WIDTH),
   parameter int CNTW  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [WIDTH-1:0]        flags,
   edge_event_serializer_if.master evt,
   output logic [WIDTH-1:0]        pending,
   output logic [CNTW-1:0]         drop_count
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int SW = CNTW + CW + 1;
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] flags_d;
   logic [WIDTH-1:0] pending_q;
   logic             valid_q;
   logic [IDXW-1:0]  index_q;
   logic [IDXW-1:0]  ptr_q;
   logic [CNTW-1:0]  drop_q;

   logic             load;
   logic             found;
   logic [IDXW-1:0]  sel;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] clear_mask;
   logic [WIDTH-1:0] dup;
   logic [CW-1:0]    dup_cnt;
   logic [SW-1:0]    sum;

   logic [WIDTH-1:0] pending_n;
   logic             valid_n;
   logic [IDXW-1:0]  index_n;
   logic [IDXW-1:0]  ptr_n;
   logic [CNTW-1:0]  drop_n;

   assign evt.out_valid = valid_q;
   assign evt.out_index = index_q;
   assign pending       = pending_q;
   assign drop_count    = drop_q;

   // Round-robin scan of the registered pending set starting at ptr.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         int pos;
         pos = (int'(ptr_q) + i) % WIDTH;
         if (!found && pending_q[pos]) begin
            found = 1'b1;
            sel   = IDXW'(pos);
         end
      end
   end

   // Output load, pending update and saturating duplicate count.
   always_comb begin
      load       = !valid_q || evt.out_ready;
      rise       = flags & ~flags_d;
      clear_mask = '0;
      valid_n    = valid_q;
      index_n    = index_q;
      ptr_n      = ptr_q;
      if (load) begin
         valid_n = found;
         if (found) begin
            index_n         = sel;
            clear_mask[sel] = 1'b1;
            if (int'(sel) == WIDTH - 1)
               ptr_n = '0;
            else
               ptr_n = sel + 1'b1;
         end
      end
      pending_n = (pending_q & ~clear_mask) | rise;
      // A rise on the bit being loaded re-queues; it is not a dup.
      dup     = rise & pending_q & ~clear_mask;
      dup_cnt = '0;
      for (int i = 0; i < WIDTH; i++)
         dup_cnt = dup_cnt + CW'(dup[i]);
      sum = SW'(drop_q) + SW'(dup_cnt);
      if (sum > SW'(CNT_MAX))
         drop_n = CNT_MAX;
      else
         drop_n = sum[CNTW-1:0];
   end

   // State registers with synchronous reset taking priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_d   <= '0;
         pending_q <= '0;
         valid_q   <= 1'b0;
         index_q   <= '0;
         ptr_q     <= '0;
         drop_q    <= '0;
      end else begin
         flags_d   <= flags;
         pending_q <= pending_n;
         valid_q   <= valid_n;
         index_q   <= index_n;
         ptr_q     <= ptr_n;
         drop_q    <= drop_n;
      end
   end

endmodule

// File: doc/edge_event_serializer.md
# edge_event_serializer

Downstream consumer of the 32-bit sticky edge-capture vector. Detects bits that newly set in the capture vector, queues them in a pending register, and emits one event index per handshake on a valid/ready port, using round-robin priority. Duplicate captures that arrive while the same index is still queued are counted, not queued twice.

## Interface
- WIDTH, 32: width of the capture vector.
- IDXW, $clog2(WIDTH): width of the event index.
- CNTW, 8: width of the drop counter.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- flags  in  WIDTH  sticky capture vector from the upstream edge-capture stage.
- out_ready  in  1  consumer accepts the event when high with out_valid.
- out_valid  out  1  out_index holds a valid event.
- out_index  out  IDXW  bit position of the emitted event.
- pending  out  WIDTH  queued events not yet loaded into the output register.
- drop_count  out  CNTW  saturating count of duplicate captures.

## Operation
- Registers: flags_d, pending, out_valid, out_index, ptr (IDXW), drop_count. Reset=1 clears all of them to 0 on the next edge. Reset overrides every other update.
- rise = flags & ~flags_d. flags_d <= flags every non-reset cycle.
- The output register loads when load = !out_valid || out_ready.
- On load with pending != 0:
  - sel = the first set bit of pending, scanning ptr, ptr+1, … WIDTH-1, 0, … ptr-1.
  - out_valid <= 1, out_index <= sel, ptr <= (sel+1) mod WIDTH.
  - clear_mask = one-hot(sel).
- On load with pending == 0: out_valid <= 0, ptr unchanged, clear_mask = 0.
- Without load, out_valid, out_index and ptr hold, and clear_mask = 0.
- pending <= (pending & ~clear_mask) | rise.
- Selection uses only the registered pending. A rise in the current cycle is never selectable in the same cycle.
- dup = rise & pending & ~clear_mask.
  - drop_count <= min(drop_count + popcount(dup), 2^CNTW − 1).
  - A rise on the index being loaded in the same cycle is not a dup. It re-queues.
- Falling bits of flags (upstream reset) are ignored apart from updating flags_d.
- flags nonzero in the first cycle after reset counts as rises, because flags_d resets to 0.

## Timing
- Latency: a flags bit that is high at edge N sets pending after edge N. It can appear on out_valid/out_index after edge N+1 at the earliest.
- Throughput: one event per cycle while out_ready=1 and pending is nonzero.
- Hold: while out_valid=1 and out_ready=0, out_valid and out_index are stable, and pending only accumulates.
- Transfer: an event completes on an edge where out_valid && out_ready. The next event can be presented in that same edge's update.
- All outputs are registered and there are no combinational paths from inputs to outputs.
- Reset values: out_valid=0, out_index=0, pending=0, drop_count=0, with ptr=0 and flags_d=0 internally.

## Test plan
- Reset, then flags=0x0000_0002 at edge N with out_ready=0 -> pending=0x2 after N. After N+1: out_valid=1, out_index=1, pending=0. These hold for 5 cycles. Raising out_ready gives one transfer, then out_valid=0.
- From 0, flags=0x8000_0005 in one cycle with out_ready=1 -> out_index 0, 2, 31 on three consecutive cycles, then out_valid=0 and ptr=0.
- Round robin: after index 2 is emitted (ptr=3), pending={1,5} -> emits 5, then 1.
- Duplicate:
  - flags=0x1 with out_ready=0 -> index 0 is held in the output register.
  - flags=0x11 -> pending=0x10.
  - flags=0x0, then 0x10 -> drop_count=1 and pending stays 0x10.
  - Releasing out_ready -> emits 0, then 4, with no second 4.
- Reset mid-operation: out_valid=1, pending=0xF0, and flags held at 0x3 through a 1-cycle reset.
  - After the reset edge, all outputs are 0.
  - After release, flags 0x3 counts as rises and emits 0, then 1.
- Saturation: with CNTW=8, force 300 duplicates by toggling flags 0xFFFF_FFFF/0 while stalled with pending full -> drop_count saturates at 255 and never wraps.
